wallace_prod_accumulator: RTL and testbench
===========================================

Name: wallace_prod_accumulator

Overview:
- Downstream stage of the 32x32 Wallace multiplier. It consumes the registered 64-bit products as a valid/ready stream and sums them into a wide accumulator, one group at a time.
- A group ends on a beat flagged last. The group sum, beat count and overflow flag are then presented on a registered valid/ready output port, for dot-product and MAC use.
- Backpressure from the output port stalls product intake.

Parameters:
- PROD_W, 64, product width; matches the multiplier output.
- ACC_W, 72, accumulator width; must be at least PROD_W. Provides 8 guard bits, enough for 256 full-scale products.
- CNT_W, 16, beat-counter width.

Ports:
- clk  input  1  rising-edge clock, shared with the multiplier.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_prod/in_last are valid this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- in_prod  input  PROD_W  unsigned product from the multiplier.
- in_last  input  1  this beat closes the current group.
- out_valid  output  1  out_acc/out_count/out_ovf hold a completed group.
- out_ready  input  1  consumer accepts the result this cycle.
- out_acc  output  ACC_W  group sum, modulo 2^ACC_W.
- out_count  output  CNT_W  number of beats in the group, saturating.
- out_ovf  output  1  group sum exceeded 2^ACC_W-1 at least once.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_acc=0, out_count=0, out_ovf=0.
  - Internal acc=0, cnt=0, ovf=0, state=IDLE.
  - A partial group in progress is discarded; no result is emitted for it.
- Handshakes:
  - Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready = ~out_valid | out_ready. This is combinational from out_ready and has no dependence on in_valid.
  - While out_valid=1, out_acc, out_count and out_ovf stay stable until the output transfer.
- Arithmetic:
  - in_prod is zero-extended to ACC_W+1 bits.
  - sum = base + ext(in_prod), where base=0 in IDLE and base=acc in ACCUM.
  - The new accumulator value is sum[ACC_W-1:0].
  - Overflow term = sum[ACC_W] OR'd with the sticky ovf. ovf is forced to 0 when state is IDLE.
  - The new count is base_cnt+1, saturating at 2^CNT_W-1. base_cnt=0 in IDLE and cnt in ACCUM.
- State machine (group tracking):
  - IDLE: no beat of the current group has been accepted.
    - Accept with in_last=0: acc<=sum, cnt<=1, ovf<=sum[ACC_W], go to ACCUM.
    - Accept with in_last=1: emit a single-beat group (count 1) and stay in IDLE.
  - ACCUM: at least one beat accumulated.
    - Accept with in_last=0: update acc, cnt and ovf; stay in ACCUM.
    - Accept with in_last=1: emit the group, clear acc/cnt/ovf, go to IDLE.
  - No accept: state and accumulator hold.
- Emit (registered, 1-cycle latency from the last beat):
  - Next edge: out_acc<=sum[ACC_W-1:0], out_count<=new count, out_ovf<=overflow term, out_valid<=1.
- Output register update, in priority order:
  - Emit has priority. If a transfer and an emit happen in the same cycle, the new result replaces the old one and out_valid stays 1.
  - Transfer without emit: out_valid<=0 next edge; data fields hold their old values.
  - Neither: hold.
- Throughput and boundaries:
  - Sustained 1 beat/cycle, including back-to-back single-beat groups, provided out_ready=1.
  - With out_valid=1 and out_ready=0, in_ready=0 and the accumulator does not advance.
  - Accumulation wraps modulo 2^ACC_W and sets out_ovf; the wrap is never silent.
  - Count saturates and does not wrap.
  - in_last on a cycle without an accept has no effect.
  - in_prod is don't-care when in_valid=0.

Test Plan:
- Reset with in_valid held 1 -> out_valid=0, out_acc=0, in_ready=1; deassert rst_n mid-group after beats 5,7 then release -> next group 3(last) yields out_acc=3, out_count=1.
- Group 10,20,30(last), out_ready=1 -> one cycle after the last accept: out_valid=1, out_acc=60, out_count=3, out_ovf=0; out_valid drops the following cycle.
- Back-to-back single-beat groups 1,2,3 (all last), out_ready=1 -> out_acc sequence 1,2,3 on consecutive cycles, out_valid high for 3 cycles, in_ready constantly 1.
- Backpressure: group 4,4(last), then out_ready=0 for 5 cycles with next beats 9(last) presented -> in_ready=0, out_acc=8 held stable; on out_ready=1, 8 transfers and 9 is accepted the same cycle; out_acc=9 on the next cycle.
- Overflow: 257 beats of 2^64-1 (0xFFFF_FFFF_FFFF_FFFF) -> out_count=257, out_ovf=1, out_acc=(257*(2^64-1)) mod 2^72.
- Count saturation with CNT_W=4: 20 beats of 1 (last on the 20th) -> out_count=15, out_acc=20, out_ovf=0.

Source files
------------

// File: rtl/wallace_prod_accumulator.sv
// Sums a valid/ready stream of multiplier products into per-group totals.
// Each group closes on a beat flagged last and is presented on a registered valid/ready result port.
module wallace_prod_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept, emit, xfer;
  logic [ACC_W-1:0]   base;
  logic [CNT_W-1:0]   base_cnt, cnt_new;
  logic [ACC_W:0]     sum;
  logic               ovf_term;

  // A pending result may be replaced in the cycle it transfers, so intake only waits on a stalled output.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign emit     = accept & in_last;
  assign xfer     = out_valid_q & out_ready;

  always_comb begin
    base     = (state_q == ACCUM) ? acc_q : '0;
    base_cnt = (state_q == ACCUM) ? cnt_q : '0;
    sum      = {1'b0, base} + (ACC_W+1)'(in_prod);
    ovf_term = sum[ACC_W] | ((state_q == ACCUM) & ovf_q);
    cnt_new  = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (accept) begin
      if (in_last) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum[ACC_W-1:0];
        cnt_d   = cnt_new;
        ovf_d   = ovf_term;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_acc_d   = sum[ACC_W-1:0];
      out_count_d = cnt_new;
      out_ovf_d   = ovf_term;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_wallace_prod_accumulator.sv
// Bench for wallace_prod_accumulator: a group-level reference model checked every cycle,
// directed boundary cases with literal expectations, then randomized traffic and backpressure.
module tb_wallace_prod_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [63:0] in_prod;

  logic        in_ready, out_valid, out_ovf;
  logic [71:0] out_acc;
  logic [15:0] out_count;

  logic        in_ready4, out_valid4, out_ovf4;
  logic [71:0] out_acc4;
  logic [3:0]  out_count4;

  int n_total = 0;
  int n_fail  = 0;

  wallace_prod_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  wallace_prod_accumulator #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
    .out_acc(out_acc4), .out_count(out_count4), .out_ovf(out_ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: group sum kept exact in 128 bits; wrap, overflow and saturation derived from it.
  logic [127:0] m_sum, m_s;
  int           m_n, m_nn;
  logic         m_acc_en;
  logic         m_valid, m_ovf;
  logic [71:0]  m_acc;
  logic [15:0]  m_cnt;
  logic [3:0]   m_cnt4;

  always_comb begin
    m_s      = m_sum + 128'(in_prod);
    m_nn     = m_n + 1;
    m_acc_en = in_valid && (!m_valid || out_ready);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum <= '0; m_n <= 0; m_valid <= 1'b0;
      m_acc <= '0; m_cnt <= '0; m_cnt4 <= '0; m_ovf <= 1'b0;
    end else if (m_acc_en && in_last) begin
      m_valid <= 1'b1;
      m_acc   <= m_s[71:0];
      m_ovf   <= (m_s >= (128'd1 << 72));
      m_cnt   <= (m_nn > 65535) ? 16'hFFFF : 16'(m_nn);
      m_cnt4  <= (m_nn > 15) ? 4'hF : 4'(m_nn);
      m_sum   <= '0;
      m_n     <= 0;
    end else begin
      if (m_acc_en) begin
        m_sum <= m_s;
        m_n   <= m_nn;
      end
      if (m_valid && out_ready) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_acc", out_acc, m_acc);
    chk("out_count", out_count, m_cnt);
    chk("out_ovf", out_ovf, m_ovf);
    chk("out_valid4", out_valid4, m_valid);
    chk("in_ready4", in_ready4, !m_valid || out_ready);
    chk("out_acc4", out_acc4, m_acc);
    chk("out_count4", out_count4, m_cnt4);
    chk("out_ovf4", out_ovf4, m_ovf);
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [63:0] p, input logic l);
    int k = 0;
    in_valid = 1'b1; in_prod = p; in_last = l;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_prod = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;

    // Reset with traffic presented
    in_valid = 1'b1; in_prod = 64'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_acc", out_acc, 72'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Partial group discarded by reset
    send(64'd5, 1'b0);
    send(64'd7, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(64'd3, 1'b1);
    chk("post_rst_acc", out_acc, 72'd3);
    chk("post_rst_cnt", out_count, 16'd1);

    // Three-beat group
    send(64'd10, 1'b0);
    send(64'd20, 1'b0);
    send(64'd30, 1'b1);
    chk("grp_valid", out_valid, 1'b1);
    chk("grp_acc", out_acc, 72'd60);
    chk("grp_cnt", out_count, 16'd3);
    chk("grp_ovf", out_ovf, 1'b0);
    @(posedge clk); #1;
    chk("grp_valid_drop", out_valid, 1'b0);

    // Back-to-back single-beat groups
    for (int i = 1; i <= 3; i++) begin
      send(64'(i), 1'b1);
      chk("b2b_acc", out_acc, 72'(i));
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_in_ready", in_ready, 1'b1);
    end
    @(posedge clk); #1;
    chk("b2b_valid_drop", out_valid, 1'b0);

    // Backpressure holds result and stalls intake
    send(64'd4, 1'b0);
    send(64'd4, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_prod = 64'd9; in_last = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_acc_hold", out_acc, 72'd8);
      chk("bp_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    send(64'd9, 1'b1);
    chk("bp_release_acc", out_acc, 72'd9);
    chk("bp_release_cnt", out_count, 16'd1);

    // Overflow: 257 full-scale products
    for (int i = 0; i < 256; i++) send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("ovf_cnt", out_count, 16'd257);
    chk("ovf_flag", out_ovf, 1'b1);
    chk("ovf_acc", out_acc, 72'h00_FFFF_FFFF_FFFF_FEFF);
    chk("ovf_cnt4", out_count4, 4'd15);

    // Count saturation on the narrow counter
    for (int i = 1; i <= 20; i++) send(64'd1, (i == 20));
    chk("sat_cnt4", out_count4, 4'd15);
    chk("sat_acc4", out_acc4, 72'd20);
    chk("sat_ovf4", out_ovf4, 1'b0);
    chk("sat_cnt", out_count, 16'd20);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       in_prod = 64'($urandom_range(0, 255));
        1:       in_prod = {$urandom, $urandom};
        default: in_prod = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
